// File: rtl/stack_op_sequencer_if.sv
// Command channel between the instruction decoder and stack_op_sequencer.
// The decoder is the master; the sequencer is the slave.
interface stack_op_sequencer_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_op;
  logic [2:0]            cmd_src;
  logic [ADDR_WIDTH-1:0] cmd_tos;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_src,
    output cmd_tos,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_src,
    input  cmd_tos,
    output cmd_ready
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: command-level controller for the operand-stack / TOS
// datapath. Takes one command at a time over the cmd interface and sequences
// the datapath's register enables, mux selects and memory write strobes,
// while keeping a shadow copy of the TOS register in 'depth'.
//
// Optional feature macro: STACK_SEQ_PERF_EN
//   defined     -> perf_ops / perf_errs are saturating 16-bit event counters
//   not defined -> perf_ops / perf_errs are tied to zero, no counters built
module stack_op_sequencer #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  stack_op_sequencer_if.slave   cmd,
  output logic [ADDR_WIDTH-1:0] tos_ret_val,
  output logic [2:0]            sel_mux_stack,
  output logic                  ctrl_reg_read_stack,
  output logic                  ctrl_reg_write_stack,
  output logic                  ctrl_reg_read_mem,
  output logic                  ctrl_reg_write_mem,
  output logic                  sel_mux_tos,
  output logic                  ctrl_reg_tos,
  output logic                  sel_tos_updater,
  output logic                  ctrl_stack,
  output logic                  ctrl_mem_ext,
  output logic [ADDR_WIDTH-1:0] depth,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [15:0]           perf_ops,
  output logic [15:0]           perf_errs
);

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_PUSH   = 3'd1,
    OP_POP    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_STORE  = 3'd4,
    OP_SETTOS = 3'd5
  } op_t;

  // LOAD and STORE reuse the push/pop micro-steps, but get their own states
  // because their selects and done timing differ from plain PUSH/POP.
  typedef enum logic [3:0] {
    S_IDLE,
    S_NOP,
    S_ERR,
    S_P1,
    S_P2,
    S_R1,
    S_R2,
    S_M1,
    S_M2,
    S_LP1,
    S_LP2,
    S_SR1,
    S_SR2,
    S_W1,
    S_W2,
    S_T1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] DepthFull = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] DepthOne  = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [1:0]            err_code_d;
  logic [ADDR_WIDTH-1:0] depth_q;
  logic [ADDR_WIDTH-1:0] tos_ret_val_q;
  logic                  cmd_ready_q;
  logic [2:0]            sel_mux_stack_q;
  logic                  ctrl_reg_read_stack_q;
  logic                  ctrl_reg_write_stack_q;
  logic                  ctrl_reg_read_mem_q;
  logic                  ctrl_reg_write_mem_q;
  logic                  sel_mux_tos_q;
  logic                  ctrl_reg_tos_q;
  logic                  sel_tos_updater_q;
  logic                  ctrl_stack_q;
  logic                  ctrl_mem_ext_q;
  logic                  done_q;
  logic                  err_q;
  logic [1:0]            err_code_q;

  logic accept;
  logic src_legal;
  logic is_full;
  logic is_empty;

  assign accept    = (state_q == S_IDLE) && cmd.cmd_valid;
  assign src_legal = cmd.cmd_src inside {3'b000, 3'b010, 3'b011, 3'b100};
  assign is_full   = (depth_q == DepthFull);
  assign is_empty  = (depth_q == '0);

  // Next-state: validate the command on acceptance, then walk the fixed
  // micro-step chain for that command and return to IDLE.
  always_comb begin
    state_d    = state_q;
    err_code_d = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_NOP: state_d = S_NOP;
            OP_PUSH: begin
              if (!src_legal) begin
                state_d    = S_ERR;
                err_code_d = 2'b11;
              end else if (is_full) begin
                state_d    = S_ERR;
                err_code_d = 2'b01;
              end else begin
                state_d = S_P1;
              end
            end
            OP_POP: begin
              if (is_empty) begin
                state_d    = S_ERR;
                err_code_d = 2'b10;
              end else begin
                state_d = S_R1;
              end
            end
            OP_LOAD: begin
              if (is_full) begin
                state_d    = S_ERR;
                err_code_d = 2'b01;
              end else begin
                state_d = S_M1;
              end
            end
            OP_STORE: begin
              if (is_empty) begin
                state_d    = S_ERR;
                err_code_d = 2'b10;
              end else begin
                state_d = S_SR1;
              end
            end
            OP_SETTOS: state_d = S_T1;
            default: begin
              state_d    = S_ERR;
              err_code_d = 2'b11;
            end
          endcase
        end
      end
      S_P1:   state_d = S_P2;
      S_R1:   state_d = S_R2;
      S_M1:   state_d = S_M2;
      S_M2:   state_d = S_LP1;
      S_LP1:  state_d = S_LP2;
      S_SR1:  state_d = S_SR2;
      S_SR2:  state_d = S_W1;
      S_W1:   state_d = S_W2;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, shadow depth, latched TOS value and all strobes. Strobes are
  // registered decodes of the state being entered, so they line up exactly
  // with the state they belong to and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q                <= S_IDLE;
      depth_q                <= '0;
      tos_ret_val_q          <= '0;
      cmd_ready_q            <= 1'b1;
      sel_mux_stack_q        <= 3'b000;
      ctrl_reg_read_stack_q  <= 1'b0;
      ctrl_reg_write_stack_q <= 1'b0;
      ctrl_reg_read_mem_q    <= 1'b0;
      ctrl_reg_write_mem_q   <= 1'b0;
      sel_mux_tos_q          <= 1'b0;
      ctrl_reg_tos_q         <= 1'b0;
      sel_tos_updater_q      <= 1'b0;
      ctrl_stack_q           <= 1'b0;
      ctrl_mem_ext_q         <= 1'b0;
      done_q                 <= 1'b0;
      err_q                  <= 1'b0;
      err_code_q             <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= (state_d == S_IDLE);

      if (accept && (cmd.cmd_op == OP_SETTOS)) begin
        tos_ret_val_q <= cmd.cmd_tos;
      end

      // The shadow depth moves on the same edge the datapath TOS register
      // is enabled, so both always hold the same value.
      case (state_q)
        S_P1, S_LP1:  depth_q <= depth_q + DepthOne;
        S_R2, S_SR2:  depth_q <= depth_q - DepthOne;
        S_T1:         depth_q <= tos_ret_val_q;
        default:      depth_q <= depth_q;
      endcase

      // S_P1 can only be entered straight from acceptance, so the live
      // cmd_src is the accepted one.
      if (state_d == S_P1) begin
        sel_mux_stack_q <= cmd.cmd_src;
      end else if (state_d == S_LP1) begin
        sel_mux_stack_q <= 3'b001;
      end else begin
        sel_mux_stack_q <= 3'b000;
      end

      ctrl_reg_write_stack_q <= (state_d == S_P1) || (state_d == S_LP1);
      ctrl_reg_read_stack_q  <= (state_d == S_R2) || (state_d == S_SR2);
      sel_tos_updater_q      <= (state_d == S_R2) || (state_d == S_SR2);
      ctrl_reg_tos_q         <= (state_d == S_P1) || (state_d == S_LP1) ||
                                (state_d == S_R2) || (state_d == S_SR2) ||
                                (state_d == S_T1);
      ctrl_reg_read_mem_q    <= (state_d == S_M2);
      ctrl_reg_write_mem_q   <= (state_d == S_W1);
      sel_mux_tos_q          <= (state_d == S_T1);
      ctrl_stack_q           <= (state_d == S_P2) || (state_d == S_LP2);
      ctrl_mem_ext_q         <= (state_d == S_W2);
      done_q                 <= (state_d == S_NOP) || (state_d == S_P2) ||
                                (state_d == S_R2)  || (state_d == S_LP2) ||
                                (state_d == S_W2)  || (state_d == S_T1);
      err_q                  <= (state_d == S_ERR);
      err_code_q             <= err_code_d;
    end
  end

  assign cmd.cmd_ready         = cmd_ready_q;
  assign tos_ret_val           = tos_ret_val_q;
  assign sel_mux_stack         = sel_mux_stack_q;
  assign ctrl_reg_read_stack   = ctrl_reg_read_stack_q;
  assign ctrl_reg_write_stack  = ctrl_reg_write_stack_q;
  assign ctrl_reg_read_mem     = ctrl_reg_read_mem_q;
  assign ctrl_reg_write_mem    = ctrl_reg_write_mem_q;
  assign sel_mux_tos           = sel_mux_tos_q;
  assign ctrl_reg_tos          = ctrl_reg_tos_q;
  assign sel_tos_updater       = sel_tos_updater_q;
  assign ctrl_stack            = ctrl_stack_q;
  assign ctrl_mem_ext          = ctrl_mem_ext_q;
  assign depth                 = depth_q;
  assign done                  = done_q;
  assign err                   = err_q;
  assign err_code              = err_code_q;

`ifdef STACK_SEQ_PERF_EN
  logic [15:0] perf_ops_q;
  logic [15:0] perf_errs_q;

  // Saturating counts of completed and rejected commands, one per pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_ops_q  <= 16'h0000;
      perf_errs_q <= 16'h0000;
    end else begin
      if (done_q && (perf_ops_q != 16'hFFFF)) begin
        perf_ops_q <= perf_ops_q + 16'h0001;
      end
      if (err_q && (perf_errs_q != 16'hFFFF)) begin
        perf_errs_q <= perf_errs_q + 16'h0001;
      end
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_errs = perf_errs_q;
`else
  assign perf_ops  = 16'h0000;
  assign perf_errs = 16'h0000;
`endif

endmodule
